// File: rtl/obuf_responder_if.sv
// obuf_responder_if: bundles the MAC-array memory port, the drain control
// inputs and the host-facing drain stream of the output buffer.
// The parity error outputs exist only when OBUF_PARITY_EN is defined.
interface obuf_responder_if #(
    parameter int DW = 64,
    parameter int AW = 4
);
    logic          EN_O;
    logic          RW_O;
    logic [AW-1:0] ADDR_O;
    logic [DW-1:0] WDATA_O;
    logic [DW-1:0] RDATA_O;
    logic          DRAIN_START;
    logic [AW-1:0] DRAIN_BASE;
    logic [AW:0]   DRAIN_LEN;
    logic          BUSY;
    logic [DW-1:0] OUT_DATA;
    logic          OUT_VALID;
    logic          OUT_LAST;
    logic          OUT_READY;
    logic          DRAIN_DONE;
`ifdef OBUF_PARITY_EN
    logic          PAR_ERR;
    logic [AW-1:0] ERR_ADDR;

    modport master (
        output EN_O, RW_O, ADDR_O, WDATA_O, DRAIN_START, DRAIN_BASE, DRAIN_LEN, OUT_READY,
        input  RDATA_O, BUSY, OUT_DATA, OUT_VALID, OUT_LAST, DRAIN_DONE, PAR_ERR, ERR_ADDR
    );
    modport slave (
        input  EN_O, RW_O, ADDR_O, WDATA_O, DRAIN_START, DRAIN_BASE, DRAIN_LEN, OUT_READY,
        output RDATA_O, BUSY, OUT_DATA, OUT_VALID, OUT_LAST, DRAIN_DONE, PAR_ERR, ERR_ADDR
    );
`else
    modport master (
        output EN_O, RW_O, ADDR_O, WDATA_O, DRAIN_START, DRAIN_BASE, DRAIN_LEN, OUT_READY,
        input  RDATA_O, BUSY, OUT_DATA, OUT_VALID, OUT_LAST, DRAIN_DONE
    );
    modport slave (
        input  EN_O, RW_O, ADDR_O, WDATA_O, DRAIN_START, DRAIN_BASE, DRAIN_LEN, OUT_READY,
        output RDATA_O, BUSY, OUT_DATA, OUT_VALID, OUT_LAST, DRAIN_DONE
    );
`endif
endinterface

// File: rtl/obuf_responder.sv
// obuf_responder: 2**AW x DW single-ported output buffer answering the MAC
// array port, plus a drain engine that streams stored words to the host over
// valid/ready. The array port always owns the storage; the drain engine only
// reads in cycles where EN_O is low.
// Optional feature macro: OBUF_PARITY_EN (per-entry even parity, sticky
// PAR_ERR and first failing ERR_ADDR).
module obuf_responder #(
    parameter int DW = 64,
    parameter int AW = 4
) (
    input logic             CLK,
    input logic             RST,
    obuf_responder_if.slave bus
);
    localparam int DEPTH = 2 ** AW;
    localparam logic [AW:0] FULL_LEN = (AW + 1)'(DEPTH);
    localparam logic [AW:0] ONE_LEN  = (AW + 1)'(1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT,
        PRESENT,
        DONE
    } state_t;

    logic [DW-1:0] mem [DEPTH];

    state_t        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [AW:0]   rem_q, rem_d;
    logic [DW-1:0] out_data_q, out_data_d;
    logic          out_valid_q, out_valid_d;
    logic          out_last_q, out_last_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [DW-1:0] rdata_q;
    logic [DW-1:0] fetch_q;

    logic          array_rd;
    logic          array_wr;
    logic          drain_rd;
    logic [AW:0]   len_sat;

    assign array_rd = bus.EN_O & ~bus.RW_O;
    assign array_wr = bus.EN_O & bus.RW_O;
    assign drain_rd = (state_q == FETCH) & ~bus.EN_O;
    assign len_sat  = (bus.DRAIN_LEN > FULL_LEN) ? FULL_LEN : bus.DRAIN_LEN;

    // Storage write port; contents deliberately survive reset.
    always_ff @(posedge CLK) begin
        if (array_wr) begin
            mem[bus.ADDR_O] <= bus.WDATA_O;
        end
    end

    // Read registers: array reads hold until the next array read, drain reads feed WAIT.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rdata_q <= '0;
            fetch_q <= '0;
        end else begin
            if (array_rd) begin
                rdata_q <= mem[bus.ADDR_O];
            end
            if (drain_rd) begin
                fetch_q <= mem[addr_q];
            end
        end
    end

    // Drain FSM state and registered stream outputs.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            rem_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            rem_q       <= rem_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    // Drain next-state: fetch only when the array is idle, present, then advance on handshake.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        rem_d       = rem_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.DRAIN_START) begin
                    if (len_sat == '0) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        addr_d  = bus.DRAIN_BASE;
                        rem_d   = len_sat;
                        busy_d  = 1'b1;
                        state_d = FETCH;
                    end
                end
            end
            FETCH: begin
                if (!bus.EN_O) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                out_data_d  = fetch_q;
                out_valid_d = 1'b1;
                out_last_d  = (rem_q == ONE_LEN);
                state_d     = PRESENT;
            end
            PRESENT: begin
                if (bus.OUT_READY) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    addr_d      = addr_q + AW'(1);
                    rem_d       = rem_q - ONE_LEN;
                    if (rem_q == ONE_LEN) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = FETCH;
                    end
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.RDATA_O    = rdata_q;
    assign bus.OUT_DATA   = out_data_q;
    assign bus.OUT_VALID  = out_valid_q;
    assign bus.OUT_LAST   = out_last_q;
    assign bus.BUSY       = busy_q;
    assign bus.DRAIN_DONE = done_q;

`ifdef OBUF_PARITY_EN
    logic          par_mem [DEPTH];
    logic          par_err_q;
    logic [AW-1:0] err_addr_q;
    logic [AW-1:0] chk_addr;
    logic          chk_bad;

    // Parity bit store, computed alongside every array write.
    always_ff @(posedge CLK) begin
        if (array_wr) begin
            par_mem[bus.ADDR_O] <= ^bus.WDATA_O;
        end
    end

    // Recheck parity on whichever read (array or drain) uses the storage this cycle.
    always_comb begin
        chk_addr = array_rd ? bus.ADDR_O : addr_q;
        chk_bad  = 1'b0;
        if (array_rd || drain_rd) begin
            chk_bad = ((^mem[chk_addr]) != par_mem[chk_addr]);
        end
    end

    // Sticky error flag that remembers only the first failing address.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            par_err_q  <= 1'b0;
            err_addr_q <= '0;
        end else if (chk_bad && !par_err_q) begin
            par_err_q  <= 1'b1;
            err_addr_q <= chk_addr;
        end
    end

    assign bus.PAR_ERR  = par_err_q;
    assign bus.ERR_ADDR = err_addr_q;
`endif
endmodule

// File: tb/tb_obuf_responder.sv
// tb_obuf_responder: directed bench for obuf_responder. A table of array-port
// vectors checks reads/writes; hand-written sequences cover drains, stalls,
// back-pressure, zero-length and restart, and reset mid-drain. A bench-side
// copy of the storage provides all expected drain data.
// Optional feature macro: OBUF_PARITY_EN enables the parity sequence.
module tb_obuf_responder;
    logic CLK;
    logic RST;
    int   total;
    int   bad;
    logic [63:0] model [16];

    typedef struct {
        logic        en;
        logic        rw;
        logic [3:0]  addr;
        logic [63:0] wdata;
        logic [63:0] exp_rdata;
    } vec_t;

    vec_t vecs [13];

    obuf_responder_if #(.DW(64), .AW(4)) bus ();

    obuf_responder #(.DW(64), .AW(4)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic apply_stimulus(input logic en, input logic rw, input logic [3:0] addr, input logic [63:0] wdata);
        bus.EN_O    = en;
        bus.RW_O    = rw;
        bus.ADDR_O  = addr;
        bus.WDATA_O = wdata;
        tick();
        if (en && rw) begin
            model[addr] = wdata;
        end
        bus.EN_O = 1'b0;
        bus.RW_O = 1'b0;
    endtask

    task automatic drain_run(input logic [3:0] base, input logic [4:0] len, input int exp_beats,
                             input bit toggle, input bit restart);
        int          beats;
        int          holds;
        int          cyc;
        bit          done_seen;
        bit          hs_last;
        bit          holding;
        bit          rdy;
        logic [63:0] held;
        beats = 0; holds = 0; done_seen = 0; hs_last = 0; holding = 0; rdy = 1'b0; held = '0;
        bus.DRAIN_BASE  = base;
        bus.DRAIN_LEN   = len;
        bus.DRAIN_START = 1'b1;
        tick();
        bus.DRAIN_START = 1'b0;
        for (cyc = 0; cyc < 300 && !done_seen; cyc++) begin
            rdy = toggle ? ~rdy : 1'b1;
            bus.OUT_READY = rdy;
            if (restart && cyc == 1) begin
                bus.DRAIN_BASE  = 4'd0;
                bus.DRAIN_LEN   = 5'd16;
                bus.DRAIN_START = 1'b1;
            end else begin
                bus.DRAIN_START = 1'b0;
            end
            if (cyc == 0 && exp_beats > 0) check_output("busy_during_drain", 64'(bus.BUSY), 64'd1);
            if (holding) begin
                check_output("hold_data", bus.OUT_DATA, held);
                check_output("hold_valid", 64'(bus.OUT_VALID), 64'd1);
            end
            if (bus.DRAIN_DONE) begin
                done_seen = 1;
                check_output("done_after_last", 64'(hs_last), 64'(exp_beats > 0));
                if (exp_beats == 0) check_output("len0_done_latency", 64'(cyc), 64'd0);
            end
            hs_last = 0;
            holding = 0;
            if (bus.OUT_VALID) begin
                if (rdy) begin
                    check_output("beat_data", bus.OUT_DATA, model[4'(base + 4'(beats))]);
                    check_output("beat_last", 64'(bus.OUT_LAST), 64'(beats == exp_beats - 1));
                    beats++;
                    hs_last = 1;
                end else begin
                    held    = bus.OUT_DATA;
                    holding = 1;
                    holds++;
                end
            end
            if (!done_seen) tick();
        end
        bus.DRAIN_START = 1'b0;
        bus.OUT_READY   = 1'b0;
        check_output("beat_count", 64'(beats), 64'(exp_beats));
        check_output("done_seen", 64'(done_seen), 64'd1);
        if (toggle) check_output("backpressure_seen", 64'(holds > 0), 64'd1);
        tick();
        check_output("busy_after_done", 64'(bus.BUSY), 64'd0);
        check_output("done_one_cycle", 64'(bus.DRAIN_DONE), 64'd0);
    endtask

    initial begin
        int  seen;
        bit  stall_ok;
        bit  quiet;
        logic [3:0]  waddr [6];
        logic [63:0] wdat  [6];

        total = 0;
        bad   = 0;
        vecs[0]  = '{1'b1, 1'b1, 4'd3,  64'h0123456789ABCDEF, 64'h0};
        vecs[1]  = '{1'b1, 1'b0, 4'd3,  64'h0,                64'h0123456789ABCDEF};
        vecs[2]  = '{1'b0, 1'b0, 4'd0,  64'h0,                64'h0123456789ABCDEF};
        vecs[3]  = '{1'b0, 1'b0, 4'd0,  64'h0,                64'h0123456789ABCDEF};
        vecs[4]  = '{1'b0, 1'b0, 4'd0,  64'h0,                64'h0123456789ABCDEF};
        vecs[5]  = '{1'b0, 1'b0, 4'd0,  64'h0,                64'h0123456789ABCDEF};
        vecs[6]  = '{1'b0, 1'b0, 4'd0,  64'h0,                64'h0123456789ABCDEF};
        vecs[7]  = '{1'b1, 1'b1, 4'd3,  64'h55AA,             64'h0123456789ABCDEF};
        vecs[8]  = '{1'b1, 1'b0, 4'd3,  64'h0,                64'h55AA};
        vecs[9]  = '{1'b1, 1'b1, 4'd12, 64'hCAFE,             64'h55AA};
        vecs[10] = '{1'b1, 1'b0, 4'd12, 64'h0,                64'hCAFE};
        vecs[11] = '{1'b1, 1'b0, 4'd3,  64'h0,                64'h55AA};
        vecs[12] = '{1'b0, 1'b0, 4'd0,  64'h0,                64'h55AA};

        RST = 1'b1;
        bus.EN_O = 1'b0; bus.RW_O = 1'b0; bus.ADDR_O = '0; bus.WDATA_O = '0;
        bus.DRAIN_START = 1'b0; bus.DRAIN_BASE = '0; bus.DRAIN_LEN = '0; bus.OUT_READY = 1'b0;
        for (int i = 0; i < 16; i++) model[i] = '0;
        tick();
        tick();
        check_output("rst_rdata", bus.RDATA_O, 64'h0);
        check_output("rst_out_data", bus.OUT_DATA, 64'h0);
        check_output("rst_out_valid", 64'(bus.OUT_VALID), 64'd0);
        check_output("rst_out_last", 64'(bus.OUT_LAST), 64'd0);
        check_output("rst_busy", 64'(bus.BUSY), 64'd0);
        check_output("rst_done", 64'(bus.DRAIN_DONE), 64'd0);
        RST = 1'b0;
        tick();

        for (int i = 0; i < 13; i++) begin
            apply_stimulus(vecs[i].en, vecs[i].rw, vecs[i].addr, vecs[i].wdata);
            check_output($sformatf("vec%0d_rdata", i), bus.RDATA_O, vecs[i].exp_rdata);
        end

        for (int i = 0; i < 16; i++) begin
            apply_stimulus(1'b1, 1'b1, 4'(i), 64'(i) * 64'h1111);
        end

        drain_run(4'd0, 5'd16, 16, 1'b0, 1'b0);
        drain_run(4'd14, 5'd4, 4, 1'b1, 1'b0);
        drain_run(4'd5, 5'd20, 16, 1'b0, 1'b0);
        drain_run(4'd0, 5'd0, 0, 1'b0, 1'b0);
        drain_run(4'd2, 5'd3, 3, 1'b0, 1'b1);

        waddr = '{4'd10, 4'd11, 4'd9, 4'd12, 4'd13, 4'd14};
        wdat  = '{64'h1000, 64'h1001, 64'hDEAD, 64'h1003, 64'h1004, 64'h1005};
        bus.OUT_READY   = 1'b0;
        bus.DRAIN_BASE  = 4'd9;
        bus.DRAIN_LEN   = 5'd1;
        bus.DRAIN_START = 1'b1;
        tick();
        bus.DRAIN_START = 1'b0;
        stall_ok = 1;
        for (int i = 0; i < 6; i++) begin
            bus.EN_O = 1'b1; bus.RW_O = 1'b1; bus.ADDR_O = waddr[i]; bus.WDATA_O = wdat[i];
            tick();
            model[waddr[i]] = wdat[i];
            if (bus.OUT_VALID || !bus.BUSY) stall_ok = 0;
        end
        bus.EN_O = 1'b0; bus.RW_O = 1'b0;
        check_output("stall_no_beat", 64'(stall_ok), 64'd1);
        tick();
        check_output("stall_fetch_valid", 64'(bus.OUT_VALID), 64'd0);
        tick();
        check_output("stall_valid", 64'(bus.OUT_VALID), 64'd1);
        check_output("stall_new_data", bus.OUT_DATA, 64'hDEAD);
        check_output("stall_last", 64'(bus.OUT_LAST), 64'd1);
        apply_stimulus(1'b1, 1'b1, 4'd9, 64'hBEEF);
        check_output("captured_beat_stable", bus.OUT_DATA, 64'hDEAD);
        check_output("captured_valid_stable", 64'(bus.OUT_VALID), 64'd1);
        bus.OUT_READY = 1'b1;
        tick();
        bus.OUT_READY = 1'b0;
        check_output("stall_done", 64'(bus.DRAIN_DONE), 64'd1);
        check_output("stall_valid_drop", 64'(bus.OUT_VALID), 64'd0);
        tick();
        check_output("stall_busy_clear", 64'(bus.BUSY), 64'd0);

`ifdef OBUF_PARITY_EN
        check_output("par_err_clean", 64'(bus.PAR_ERR), 64'd0);
        dut.mem[7] = dut.mem[7] ^ 64'h1;
        model[7]   = model[7] ^ 64'h1;
        drain_run(4'd6, 5'd3, 3, 1'b0, 1'b0);
        check_output("par_err_set", 64'(bus.PAR_ERR), 64'd1);
        check_output("par_err_addr", 64'(bus.ERR_ADDR), 64'd7);
`endif

        apply_stimulus(1'b1, 1'b0, 4'd3, 64'h0);
        bus.OUT_READY   = 1'b1;
        bus.DRAIN_BASE  = 4'd0;
        bus.DRAIN_LEN   = 5'd4;
        bus.DRAIN_START = 1'b1;
        tick();
        bus.DRAIN_START = 1'b0;
        seen = 0;
        for (int cyc = 0; cyc < 50 && seen < 2; cyc++) begin
            if (bus.OUT_VALID) seen++;
            if (seen < 2) tick();
        end
        check_output("rst_reach_beat2", 64'(seen), 64'd2);
        #2 RST = 1'b1;
        #1;
        check_output("midrst_valid", 64'(bus.OUT_VALID), 64'd0);
        check_output("midrst_data", bus.OUT_DATA, 64'h0);
        check_output("midrst_last", 64'(bus.OUT_LAST), 64'd0);
        check_output("midrst_busy", 64'(bus.BUSY), 64'd0);
        check_output("midrst_rdata", bus.RDATA_O, 64'h0);
        tick();
        RST = 1'b0;
        quiet = 1;
        for (int cyc = 0; cyc < 10; cyc++) begin
            tick();
            if (bus.DRAIN_DONE || bus.OUT_VALID || bus.BUSY) quiet = 0;
        end
        check_output("midrst_no_done", 64'(quiet), 64'd1);
        bus.OUT_READY = 1'b0;
        apply_stimulus(1'b1, 1'b0, 4'd3, 64'h0);
        check_output("mem_retained", bus.RDATA_O, model[3]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
